// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Requester indices and default widths used by the arbiter slice.
package regfile_wb_arbiter_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_ADDR_W = 1;

    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LOAD = 1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two producer handshakes, the register file write
// port, and the decode-side issue/operand-status signals.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_dest;
    logic [XLEN-1:0]   req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_dest;
    logic [XLEN-1:0]   req1_data;

    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_dest;
    logic [XLEN-1:0]   rf_data_in;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic              issue_ready;

    logic [ADDR_W-1:0] src_one;
    logic [ADDR_W-1:0] src_two;
    logic              stall_one;
    logic              stall_two;

    modport master (
        output req0_valid, req0_dest, req0_data,
        input  req0_ready,
        output req1_valid, req1_dest, req1_data,
        input  req1_ready,
        input  rf_write_enable, rf_dest, rf_data_in,
        output issue_valid, issue_dest,
        input  issue_ready,
        output src_one, src_two,
        input  stall_one, stall_two
    );

    modport slave (
        input  req0_valid, req0_dest, req0_data,
        output req0_ready,
        input  req1_valid, req1_dest, req1_data,
        output req1_ready,
        output rf_write_enable, rf_dest, rf_data_in,
        input  issue_valid, issue_dest,
        output issue_ready,
        input  src_one, src_two,
        output stall_one, stall_two
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter; owns the last-grant pointer.
// The pointer moves only when the caller signals a completed transfer.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // Lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant0 = valid0 && (!valid1 || last_grant);
        grant1 = valid1 && (!valid0 || !last_grant);
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and per-register pending scoreboard.
// Optional macro RF_WB_BYPASS_EN: the write cycle itself clears stall.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [1:0]        grant;
    logic [1:0]        xfer;
    logic              advance;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dest;
    logic [XLEN-1:0]   wr_data;
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;
    logic              issue_rdy;
    logic              issue_acc;
    logic              stall_a;
    logic              stall_b;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .advance (advance),
        .grant0  (grant[WB_REQ_ALU]),
        .grant1  (grant[WB_REQ_LOAD])
    );

    // Grants imply valid, so a gated grant is both ready and transfer.
    always_comb begin
        xfer[WB_REQ_ALU]  = grant[WB_REQ_ALU] && !reset;
        xfer[WB_REQ_LOAD] = grant[WB_REQ_LOAD] && !reset;
        advance           = |xfer;
    end

    // Steer the winning producer onto the write port; idle port is zero.
    always_comb begin
        wr_en   = 1'b0;
        wr_dest = '0;
        wr_data = '0;
        unique case (1'b1)
            xfer[WB_REQ_ALU]: begin
                wr_en   = 1'b1;
                wr_dest = bus.req0_dest;
                wr_data = bus.req0_data;
            end
            xfer[WB_REQ_LOAD]: begin
                wr_en   = 1'b1;
                wr_dest = bus.req1_dest;
                wr_data = bus.req1_data;
            end
            default: ;
        endcase
    end

    // Clear on write, then set on issue so a same-cycle set wins.
    always_comb begin
        issue_rdy   = !reset && !pending[bus.issue_dest];
        issue_acc   = bus.issue_valid && issue_rdy;
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[wr_dest] = 1'b0;
        end
        if (issue_acc) begin
            pending_nxt[bus.issue_dest] = 1'b1;
        end
    end

    // Scoreboard register; reset drops every outstanding reservation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Operand status for decode, optionally bypassing the current write.
    always_comb begin
`ifdef RF_WB_BYPASS_EN
        stall_a = !reset && pending[bus.src_one]
                  && !(wr_en && wr_dest == bus.src_one);
        stall_b = !reset && pending[bus.src_two]
                  && !(wr_en && wr_dest == bus.src_two);
`else
        stall_a = !reset && pending[bus.src_one];
        stall_b = !reset && pending[bus.src_two];
`endif
    end

    assign bus.req0_ready      = xfer[WB_REQ_ALU];
    assign bus.req1_ready      = xfer[WB_REQ_LOAD];
    assign bus.rf_write_enable = wr_en;
    assign bus.rf_dest         = wr_dest;
    assign bus.rf_data_in      = wr_data;
    assign bus.issue_ready     = issue_rdy;
    assign bus.stall_one       = stall_a;
    assign bus.stall_two       = stall_b;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the register file. Shares the file's single write port (`write_enable`/`dest`/`data_in`) between two producers (req0: ALU result path, req1: load/return path) with round-robin fairness and valid/ready handshakes. Tracks outstanding writes per register and tells the decode stage when a source operand is not yet valid.

## Interface
Parameters:
- `XLEN`, 32, data width; must match the register file.
- `ADDR_W`, 1, register index width; `NREGS = 2**ADDR_W` registers tracked.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`  in  1  producer 0 has a write.
- `req0_ready`  out  1  producer 0 write accepted this cycle.
- `req0_dest`  in  ADDR_W  producer 0 target register.
- `req0_data`  in  XLEN  producer 0 write data.
- `req1_valid`, `req1_ready`, `req1_dest`, `req1_data`: same as req0, for producer 1.
- `rf_write_enable`  out  1  register file write enable.
- `rf_dest`  out  ADDR_W  register file write index.
- `rf_data_in`  out  XLEN  register file write data.
- `issue_valid`  in  1  decode reserves `issue_dest` for a future write.
- `issue_dest`  in  ADDR_W  register being reserved.
- `issue_ready`  out  1  reservation accepted.
- `src_one`, `src_two`  in  ADDR_W each  decode read indices.
- `stall_one`, `stall_two`  out  1 each  operand not yet written.

## Operation
- State: `pending[NREGS-1:0]` scoreboard bits; `last_grant` (1 bit) round-robin pointer.
- Arbitration is combinational from valids and `last_grant`:
  - one valid: grant it;
  - both valid: grant the requester ≠ `last_grant`.
- `reqN_ready = grantN`. `ready` may depend on `valid`; producers must hold `valid`/`dest`/`data` stable until `ready`.
- Transfer = `valid && ready`. `last_grant` updates to the granted index only on a transfer.
- Write port:
  - `rf_write_enable` = any transfer.
  - `rf_dest`/`rf_data_in` = granted requester's fields.
  - When no transfer: `rf_dest`/`rf_data_in` = 0.
- Scoreboard:
  - A write transfer clears `pending[rf_dest]`.
  - An accepted issue sets `pending[issue_dest]`.
  - Same register set and cleared in the same cycle: set wins.
- `issue_ready = !pending[issue_dest]`, from the registered bit only. Same-cycle clears are not bypassed. At most one outstanding writer per register (no WAW).
- A write to a non-pending register is legal: the register file is written and `pending` is unchanged.
- `stall_one = pending[src_one]`; `stall_two = pending[src_two]` (see Configuration).

## Timing
- Handshake to register file: 0-cycle. Data lands in the register file at the same rising edge as the transfer.
- Scoreboard set/clear is visible on `issue_ready`/`stall_*` in the cycle after the edge.
- Reset values: `pending = 0`, `last_grant = 1`, so req0 wins the first contention.
- While `reset` is high:
  - forced to 0: `req0_ready`, `req1_ready`, `rf_write_enable`, `rf_dest`, `rf_data_in`, `issue_ready`, `stall_one`, `stall_two`;
  - no transfer occurs.
- Reset mid-operation discards all pending reservations. Producers must re-present after reset.
- Continuous contention gives strict alternation 0,1,0,1… One requester idle lets the other win every cycle.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - `stall_x = pending[src_x] && !(rf_write_enable && rf_dest == src_x)`.
  - The consumer proceeds in the write cycle, and decode takes the operand from `rf_data_in`.
- Undefined: `stall_x = pending[src_x]`. The consumer waits until the cycle after the write.
- Arbitration, `issue_ready` and the scoreboard update rule are identical in both builds.

## Structure
- Shared package: `XLEN` and `ADDR_W` defaults; requester index constants `WB_REQ_ALU = 0` and `WB_REQ_LOAD = 1`.
- One sub-module `rr_arbiter2`:
  - 2-way round-robin;
  - inputs: `clk`, `reset`, two valids, an advance strobe;
  - outputs: two grants;
  - owns `last_grant`.
- Scoreboard and write-port muxing live in the top.

## Test plan
- **Reset:** assert `reset` with both valids high → all outputs 0. Release → first contention grants req0; `rf_dest = req0_dest`.
- **Contention:** both valid for 4 cycles with dest 0/1 and data `0xA0`/`0xB1` → grants 0,1,0,1; `rf_data_in` = A0, B1, A0, B1.
- **Scoreboard:** issue dest 1 → next cycle `issue_ready` low for dest 1 and `stall_one` high for `src_one = 1`. req1 writes dest 1 → one cycle later `stall_one` low.
- **Set-wins collision:** issue dest 0 in the same cycle as a write to dest 0 → `pending[0] = 1` afterwards.
- **Bypass build** (`RF_WB_BYPASS_EN` defined): `pending[1]`, `src_two = 1`, write to dest 1 this cycle → `stall_two = 0` in that cycle. Without the macro, `stall_two = 1` in that cycle and 0 in the next.
- **Mid-operation reset:** `pending = 2'b11` and req1 holding valid → `reset` for 1 cycle → `pending = 0`; next contention grants req0.
